// File: rtl/lfsr_test_pkg.sv
// Shared definitions for the LFSR FIFO test path: polynomial step, widths, checker states.
// The write-side generator uses the same lfsr8_next, so both ends share one sequence.
package lfsr_test_pkg;
   localparam int LFSR_W     = 8;
   localparam int ERR_CNT_W  = 16;
   localparam int WORD_CNT_W = 32;

   typedef enum logic {SEED, CHECK} chk_state_e;

   function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] x);
      return {x[6:0], x[7] ^ x[2]};
   endfunction
endpackage

// File: rtl/lfsr_stream_checker_if.sv
// FIFO read-port bundle between the test FIFO (slave) and the stream checker (master).
interface lfsr_stream_checker_if;
   import lfsr_test_pkg::*;

   logic              i_fifo_empty;
   logic [LFSR_W-1:0] iv_fifo_dout;
   logic              o_rd_en;

   modport master (output o_rd_en, input i_fifo_empty, input iv_fifo_dout);
   modport slave  (input o_rd_en, output i_fifo_empty, output iv_fifo_dout);
endinterface

// File: rtl/fifo_rd_pacer.sv
// Issues FIFO reads with RD_GAP idle cycles between them; rd_vld marks the cycle read data is valid.
module fifo_rd_pacer #(
   parameter int RD_GAP = 0
) (
   input  logic clk_rd,
   input  logic reset,
   input  logic fifo_empty,
   output logic rd_en,
   output logic rd_vld
);
   localparam int GAP_W = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;

   logic [GAP_W-1:0] gap_cnt;

   // Combinational from empty so the FIFO never sees a read while empty.
   assign rd_en = !fifo_empty && (gap_cnt == '0) && !reset;

   always_ff @(posedge clk_rd) begin
      if (reset) begin
         gap_cnt <= '0;
         rd_vld  <= 1'b0;
      end else begin
         rd_vld <= rd_en;
         if (rd_en)
            gap_cnt <= GAP_W'(RD_GAP);
         else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end
endmodule

// File: rtl/lfsr_stream_checker.sv
// Drains a test FIFO and checks each word against the LFSR sequence, with lock/resync,
// per-word error pulse, saturating error count, wrapping word count and all-zero seed flag.
module lfsr_stream_checker
   import lfsr_test_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int RESYNC_THRESH = 4,
   parameter int RD_GAP        = 0
) (
   input  logic                  clk_rd,
   input  logic                  reset,
   lfsr_stream_checker_if.master bus,
   input  logic                  i_clr_cnt,
   output logic                  o_locked,
   output logic                  o_err,
   output logic [ERR_CNT_W-1:0]  ov_err_cnt,
   output logic [WORD_CNT_W-1:0] ov_word_cnt,
   output logic                  o_stuck_zero
);
   chk_state_e            state, state_nx;
   logic                  rd_vld;
   logic [DATA_WIDTH-1:0] expected;
   logic [DATA_WIDTH-1:0] dout;
   logic [3:0]            mis_run, mis_next;
   logic                  match, err_inc;

   fifo_rd_pacer #(.RD_GAP(RD_GAP)) u_pacer (
      .clk_rd    (clk_rd),
      .reset     (reset),
      .fifo_empty(bus.i_fifo_empty),
      .rd_en     (bus.o_rd_en),
      .rd_vld    (rd_vld)
   );

   assign dout     = bus.iv_fifo_dout;
   assign match    = (dout == expected);
   assign mis_next = mis_run + 4'd1;
   assign err_inc  = rd_vld && (state == CHECK) && !match;

   always_ff @(posedge clk_rd) begin
      if (reset) state <= SEED;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (rd_vld) begin
         case (state)
            SEED:    state_nx = CHECK;
            CHECK:   if (!match && mis_next == 4'(RESYNC_THRESH)) state_nx = SEED;
            default: state_nx = SEED;
         endcase
      end
   end

   always_comb begin
      o_locked = (state == CHECK);
   end

   // On a mismatch the expected value free-runs so a lone corrupted word costs one error.
   always_ff @(posedge clk_rd) begin
      if (reset) begin
         expected <= '0;
         mis_run  <= '0;
         o_err    <= 1'b0;
      end else begin
         o_err <= err_inc;
         if (rd_vld) begin
            if (state == SEED || match) begin
               expected <= lfsr8_next(dout);
               mis_run  <= '0;
            end else begin
               expected <= lfsr8_next(expected);
               mis_run  <= mis_next;
            end
         end
      end
   end

   always_ff @(posedge clk_rd) begin
      if (reset || i_clr_cnt) begin
         ov_err_cnt   <= '0;
         ov_word_cnt  <= '0;
         o_stuck_zero <= 1'b0;
      end else begin
         if (rd_vld)
            ov_word_cnt <= ov_word_cnt + WORD_CNT_W'(1);
         if (err_inc && ov_err_cnt != '1)
            ov_err_cnt <= ov_err_cnt + ERR_CNT_W'(1);
         if (rd_vld && state == SEED && dout == '0)
            o_stuck_zero <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench: a queue-backed FIFO model feeds the checker; a second instance checks read pacing.
module tb_lfsr_stream_checker;
   import lfsr_test_pkg::*;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        gap_empty;
   logic        locked0, err0, stuck0;
   logic [15:0] err_cnt0;
   logic [31:0] word_cnt0;
   logic        locked1, err1, stuck1;
   logic [15:0] err_cnt1;
   logic [31:0] word_cnt1;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  mem [0:1023];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   lfsr_stream_checker_if bus0 ();
   lfsr_stream_checker_if bus1 ();

   lfsr_stream_checker #(.DATA_WIDTH(8), .RESYNC_THRESH(4), .RD_GAP(0)) dut (
      .clk_rd(clk), .reset(reset), .bus(bus0), .i_clr_cnt(clr),
      .o_locked(locked0), .o_err(err0), .ov_err_cnt(err_cnt0),
      .ov_word_cnt(word_cnt0), .o_stuck_zero(stuck0)
   );

   lfsr_stream_checker #(.DATA_WIDTH(8), .RESYNC_THRESH(4), .RD_GAP(3)) dut_gap (
      .clk_rd(clk), .reset(reset), .bus(bus1), .i_clr_cnt(clr),
      .o_locked(locked1), .o_err(err1), .ov_err_cnt(err_cnt1),
      .ov_word_cnt(word_cnt1), .o_stuck_zero(stuck1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign bus0.i_fifo_empty = (wr_ptr == rd_ptr);
   assign bus1.i_fifo_empty = gap_empty;
   assign bus1.iv_fifo_dout = 8'h00;

   always @(posedge clk) begin
      if (bus0.o_rd_en) begin
         bus0.iv_fifo_dout <= mem[rd_ptr];
         rd_ptr            <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clr = 1'b0;
      gap_empty = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (locked0 !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked0); end
      n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err0); end
      n_checks++; if (err_cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt0); end
      n_checks++; if (word_cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt0); end
      n_checks++; if (stuck0 !== 1'b0) begin n_fail++; $display("FAIL reset_stuck got %b want 0", stuck0); end
      n_checks++; if (bus0.o_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", bus0.o_rd_en); end
      reset = 1'b0;
   endtask

   task automatic test_clean();
      int errs;
      logic [7:0] seq [7];
      seq = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h24, 8'h49};
      do_reset();
      foreach (seq[k]) push(seq[k]);
      errs = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (err0) errs++;
         if (i == 1) begin
            n_checks++; if (locked0 !== 1'b0) begin n_fail++; $display("FAIL clean_lock_early got %b want 0", locked0); end
         end
         if (i == 2) begin
            n_checks++; if (locked0 !== 1'b1) begin n_fail++; $display("FAIL clean_lock_rise got %b want 1", locked0); end
         end
      end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL clean_err_pulses got %0d want 0", errs); end
      n_checks++; if (word_cnt0 !== 32'd7) begin n_fail++; $display("FAIL clean_word_cnt got %0d want 7", word_cnt0); end
      n_checks++; if (err_cnt0 !== 16'd0) begin n_fail++; $display("FAIL clean_err_cnt got %0d want 0", err_cnt0); end
   endtask

   task automatic test_single_corrupt();
      int errs;
      logic [7:0] seq [6];
      seq = '{8'h01, 8'h02, 8'h04, 8'hFF, 8'h12, 8'h24};
      do_reset();
      foreach (seq[k]) push(seq[k]);
      errs = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (err0) errs++;
         if (i == 5) begin
            n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL corrupt_err_on_ff got %b want 1", err0); end
         end
      end
      n_checks++; if (errs != 1) begin n_fail++; $display("FAIL corrupt_err_pulses got %0d want 1", errs); end
      n_checks++; if (err_cnt0 !== 16'd1) begin n_fail++; $display("FAIL corrupt_err_cnt got %0d want 1", err_cnt0); end
      n_checks++; if (word_cnt0 !== 32'd6) begin n_fail++; $display("FAIL corrupt_word_cnt got %0d want 6", word_cnt0); end
      n_checks++; if (locked0 !== 1'b1) begin n_fail++; $display("FAIL corrupt_locked got %b want 1", locked0); end
   endtask

   task automatic test_dropped_word();
      int errs;
      logic [7:0] seq [9];
      seq = '{8'h01, 8'h02, 8'h09, 8'h12, 8'h24, 8'h49, 8'h92, 8'h25, 8'h4B};
      do_reset();
      foreach (seq[k]) push(seq[k]);
      errs = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (err0) errs++;
         if (i == 7) begin
            n_checks++; if (locked0 !== 1'b0) begin n_fail++; $display("FAIL drop_lock_fall got %b want 0", locked0); end
            n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL drop_resync_err got %b want 1", err0); end
         end
         if (i == 8) begin
            n_checks++; if (locked0 !== 1'b1) begin n_fail++; $display("FAIL drop_reseed got %b want 1", locked0); end
         end
      end
      n_checks++; if (errs != 4) begin n_fail++; $display("FAIL drop_err_pulses got %0d want 4", errs); end
      n_checks++; if (err_cnt0 !== 16'd4) begin n_fail++; $display("FAIL drop_err_cnt got %0d want 4", err_cnt0); end
      n_checks++; if (word_cnt0 !== 32'd9) begin n_fail++; $display("FAIL drop_word_cnt got %0d want 9", word_cnt0); end
   endtask

   task automatic test_stuck_zero_and_clear();
      int errs;
      do_reset();
      for (int k = 0; k < 4; k++) push(8'h00);
      errs = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (err0) errs++;
      end
      n_checks++; if (stuck0 !== 1'b1) begin n_fail++; $display("FAIL stuck_flag got %b want 1", stuck0); end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL stuck_err_pulses got %0d want 0", errs); end
      n_checks++; if (word_cnt0 !== 32'd4) begin n_fail++; $display("FAIL stuck_word_cnt got %0d want 4", word_cnt0); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_checks++; if (stuck0 !== 1'b0) begin n_fail++; $display("FAIL clr_stuck got %b want 0", stuck0); end
      n_checks++; if (word_cnt0 !== 32'd0) begin n_fail++; $display("FAIL clr_word_cnt got %0d want 0", word_cnt0); end
      n_checks++; if (err_cnt0 !== 16'd0) begin n_fail++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt0); end
      n_checks++; if (locked0 !== 1'b1) begin n_fail++; $display("FAIL clr_locked got %b want 1", locked0); end
      // Clear lands on the same edge the next word is counted: clear must win.
      push(8'h00);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (word_cnt0 !== 32'd0) begin n_fail++; $display("FAIL clr_wins_word_cnt got %0d want 0", word_cnt0); end
   endtask

   task automatic test_mid_reset();
      int errs;
      do_reset();
      push(8'h01); push(8'h02); push(8'h04);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (bus0.o_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en got %b want 0", bus0.o_rd_en); end
      @(negedge clk);
      n_checks++; if (locked0 !== 1'b0) begin n_fail++; $display("FAIL midrst_locked got %b want 0", locked0); end
      n_checks++; if (word_cnt0 !== 32'd0) begin n_fail++; $display("FAIL midrst_word_cnt got %0d want 0", word_cnt0); end
      n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err0); end
      reset = 1'b0;
      errs = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (err0) errs++;
      end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL midrst_err_pulses got %0d want 0", errs); end
      n_checks++; if (word_cnt0 !== 32'd2) begin n_fail++; $display("FAIL midrst_word_cnt_after got %0d want 2", word_cnt0); end
      n_checks++; if (locked0 !== 1'b1) begin n_fail++; $display("FAIL midrst_relock got %b want 1", locked0); end
   endtask

   task automatic test_pacing();
      int highs;
      int misplaced;
      highs = 0;
      misplaced = 0;
      gap_empty = 1'b0;
      for (int j = 0; j < 40; j++) begin
         #1;
         if (bus1.o_rd_en) begin
            highs++;
            if (j % 4 != 0) misplaced++;
         end
         @(negedge clk);
      end
      gap_empty = 1'b1;
      n_checks++; if (highs != 10) begin n_fail++; $display("FAIL pacing_count got %0d want 10", highs); end
      n_checks++; if (misplaced != 0) begin n_fail++; $display("FAIL pacing_phase got %0d off-slot reads want 0", misplaced); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_corrupt();
      test_dropped_word();
      test_stuck_zero_and_clear();
      test_mid_reset();
      test_pacing();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
